// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline result and buffered out-of-order multiplier results.
// A small FIFO holds multiplier results; a starvation guard forces a FIFO
// grant (stalling the pipeline) after STARVE_MAX consecutive losses.
// Optional: define WB_STALL_COUNT_EN to build a saturating stall-cycle counter
// on stall_cnt; otherwise stall_cnt is tied to zero.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int MQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    input  logic [5:0]        p_opcode,
    input  logic [ADDR_W-1:0] p_dest,
    input  logic [ADDR_W-1:0] p_target,
    input  logic [DATA_W-1:0] p_data,
    input  logic [DATA_W-1:0] p_link,
    output logic              stall,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_dest,
    input  logic [DATA_W-1:0] m_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [15:0]       stall_cnt
);

    localparam int PTR_W = (MQ_DEPTH > 1) ? $clog2(MQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(MQ_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(MQ_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LAST = STV_W'(STARVE_MAX - 1);
    localparam logic [ADDR_W-1:0] LINK_REG   = ADDR_W'(31);

    localparam logic [5:0] OP_ADDU = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_MULT = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_CALL = 6'd8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mq_entry_t;

    typedef enum logic {S_NORMAL, S_FORCE} state_t;

    state_t            state_q, state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    mq_entry_t         mq_q [MQ_DEPTH];
    mq_entry_t         mq_d [MQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              p_req;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    mq_entry_t         head;

    assign fifo_empty = (count_q == '0);
    // Based on the registered count: a full FIFO refuses even while draining.
    assign m_ready    = (count_q < DEPTH_C);
    assign push       = m_valid && m_ready;
    assign head       = mq_q[rd_ptr_q];

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // Decode whether the pipeline result writes a register, and which one.
    always_comb begin
        p_req   = 1'b0;
        p_addr  = '0;
        p_wdata = p_data;
        if (p_valid) begin
            case (p_opcode)
                OP_ADDU, OP_MULT: begin
                    p_req  = 1'b1;
                    p_addr = p_target;
                end
                OP_LW, OP_ADDI: begin
                    p_req  = 1'b1;
                    p_addr = p_dest;
                end
                OP_CALL: begin
                    p_req   = 1'b1;
                    p_addr  = LINK_REG;
                    p_wdata = p_link;
                end
                default: p_req = 1'b0;
            endcase
        end
        // r0 is hardwired; never write it.
        if (p_addr == '0) p_req = 1'b0;
    end

    // Arbitration FSM: pipeline wins normally, FIFO wins when idle or forced.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        pop       = 1'b0;
        stall     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_NORMAL: begin
                if (p_req) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = p_addr;
                    wr_data_d = p_wdata;
                    if (!fifo_empty) begin
                        starve_d = starve_q + STV_W'(1);
                        if (starve_q == STARVE_LAST) state_d = S_FORCE;
                    end else begin
                        starve_d = '0;
                    end
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    starve_d = '0;
                    // Entries aimed at r0 are drained silently.
                    if (head.addr != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = head.addr;
                        wr_data_d = head.data;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            S_FORCE: begin
                pop      = !fifo_empty;
                stall    = p_req;
                starve_d = '0;
                state_d  = S_NORMAL;
                if (pop && head.addr != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = head.addr;
                    wr_data_d = head.data;
                end
            end
        endcase
    end

    // FIFO pointer/count/storage update; push and pop may coincide.
    always_comb begin
        mq_d     = mq_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mq_d[wr_ptr_q] = '{addr: m_dest, data: m_data};
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards buffered results and pending writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_NORMAL;
            starve_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < MQ_DEPTH; i++) mq_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < MQ_DEPTH; i++) mq_q[i] <= mq_d[i];
        end
    end

`ifdef WB_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count stalled cycles, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port between two requesters: the in-order pipeline result and out-of-order results from the multi-cycle multiplier.
- Decodes the pipeline opcode to decide whether a write is needed and which register it targets. Buffers multiplier results in a small FIFO.
- Drives the registered write command into the 32 x 32-bit register file. Applies a starvation guard that stalls the pipeline so buffered multiplier results cannot wait forever.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- MQ_DEPTH, 2, multiplier result FIFO entries (power of two, >=2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before a forced grant

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- p_valid  in  1  pipeline result present this cycle
- p_opcode  in  6  pipeline opcode: addu=1, beq=2, lw=3, mult=4, addi=5, j=6, nop=7, call=8
- p_dest  in  ADDR_W  dest field (used by lw, addi)
- p_target  in  ADDR_W  target field (used by addu, mult)
- p_data  in  DATA_W  result (mem_out1 equivalent)
- p_link  in  DATA_W  return address for call (mem_out2 equivalent)
- stall  out  1  pipeline must hold p_* stable; combinational
- m_valid  in  1  multiplier result offered
- m_ready  out  1  FIFO can accept; registered (= count < MQ_DEPTH)
- m_dest  in  ADDR_W  multiplier destination
- m_data  in  DATA_W  multiplier result
- wr_en  out  1  register write strobe, registered
- wr_addr  out  ADDR_W  register index, registered
- wr_data  out  DATA_W  write data, registered
- stall_cnt  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (reset=0, async): wr_en=0, wr_addr=0, wr_data=0, FIFO empty, m_ready=1, starve counter=0, FSM=S_NORMAL, stall_cnt=0. Reset asserted mid-operation discards FIFO contents and any pending write.
- Pipeline write request (p_req) decode; p_req=0 if p_valid=0:
  - addu, mult: address p_target, data p_data.
  - lw, addi: address p_dest, data p_data.
  - call: address 31, data p_link.
  - beq, j, nop, and any undefined opcode: p_req=0.
- A resolved address of 0 forces p_req=0. r0 is never written.
- Multiplier accept: enqueue when m_valid && m_ready. FIFO pointers wrap modulo MQ_DEPTH. m_ready uses the registered count, so a full FIFO refuses input even if it dequeues in the same cycle. The count update covers simultaneous push and pop (count unchanged).
- Multiplier write requests with address 0 are popped without writing.
- FSM:
  - S_NORMAL:
    - p_req=1: grant pipeline. If the FIFO is non-empty, starve++.
    - p_req=0 and FIFO non-empty: grant FIFO head (pop). starve=0.
    - starve==STARVE_MAX-1 and FIFO non-empty and p_req=1: next state S_FORCE.
    - FIFO empty: starve=0.
  - S_FORCE: grant FIFO head (pop). stall=1 if p_req=1. starve=0. Next state S_NORMAL.
- stall=1 only in S_FORCE with p_req=1. Otherwise 0.
- Latency: a granted request appears on wr_* at the next rising edge, with wr_en high for exactly that one cycle.
- A multiplier result accepted into an empty FIFO with no pipeline request is written 2 edges after acceptance.
- When nothing is granted, wr_en=0 and wr_addr/wr_data hold their previous values.
- Same-address conflict (pipeline and FIFO head target the same register): no merging. Writes land in grant order.

Optional Feature:
- Macro WB_STALL_COUNT_EN.
- Defined: stall_cnt increments by 1 on each cycle with stall=1. It saturates at 16'hFFFF and is cleared by reset.
- Not defined: stall_cnt is tied to 0 and no counter flops are built. Behaviour is otherwise identical.

Test Plan:
- Reset then p_valid=1, opcode=addu, target=7, data=32'h0000_00AA -> next edge wr_en=1, wr_addr=7, wr_data=AA. The edge after that, wr_en=0.
- opcode=call, p_link=32'd200 -> wr_addr=31, wr_data=200. opcode=beq/j/nop or lw with dest=0 -> wr_en stays 0.
- FIFO empty, m_valid=1, m_dest=5, m_data=32'h1234, no pipeline request -> m_ready=1 at accept, and wr_en=1, addr=5, data=1234 two edges later.
- Two multiplier pushes with continuous addi writes -> FIFO full, m_ready=0. After 4 pipeline grants, one cycle with stall=1 writes the FIFO head. The pipeline write held under stall lands on the following edge with no loss. With WB_STALL_COUNT_EN, stall_cnt=1.
- Simultaneous FIFO push and pop while count=1 -> count stays 1, ordering preserved (first-in written first).
- Reset asserted while FIFO holds 2 entries and wr_en=1 -> all outputs 0 immediately (asynchronously), FIFO empty, m_ready=1. No stale write after reset release.
